// File: rtl/hpdsm_demod_decimator.sv
// Receive front end for the high-pass delta-sigma stream: (-1)^n demodulation
// back to DC, then a 3rd-order CIC decimator by 2^LOG2_DECIM with a saturated output.
module hpdsm_demod_decimator #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DECIM = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    xi,
    input  logic                    xi_valid,
    output logic signed [WIDTH-1:0] yo,
    output logic                    yo_valid
);

    // Register growth of a 3rd-order CIC is 3*log2(R) bits over the 2-bit signed input.
    localparam int G     = 3 * LOG2_DECIM + 2;
    localparam int SHIFT = WIDTH - 1 - 3 * LOG2_DECIM;

    localparam logic signed [WIDTH-1:0] Y_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] Y_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic                  phase;
    logic [LOG2_DECIM-1:0] cnt;
    logic signed [G-1:0]   i1, i2, i3;
    logic                  tap_arm;
    logic signed [G-1:0]   x0, c1, c2;
    logic signed [G-1:0]   d1, d2, d3;
    logic                  v0, v1, v2;

    logic signed [G-1:0]   s;
    logic signed [G-1:0]   c3;
    logic signed [WIDTH:0] v_ext;
    logic signed [WIDTH-1:0] y_sat;

    // NOTE: every signal written in always_comb gets a value on every path; here
    // each is assigned unconditionally before any if, so no latch can be inferred.
    always_comb begin
        s     = (xi ^ phase) ? G'(1) : -G'(1);
        c3    = c2 - d3;
        v_ext = (WIDTH+1)'(c3) <<< SHIFT;
        y_sat = v_ext[WIDTH-1:0];
        if (v_ext[WIDTH] != v_ext[WIDTH-1]) begin
            y_sat = v_ext[WIDTH] ? Y_MIN : Y_MAX;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so i2 and i3 see
    // the pre-edge values of i1 and i2 exactly as the integrator chain requires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 1'b0;
            cnt      <= '0;
            i1       <= '0;
            i2       <= '0;
            i3       <= '0;
            tap_arm  <= 1'b0;
            x0       <= '0;
            c1       <= '0;
            c2       <= '0;
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            yo       <= '0;
            yo_valid <= 1'b0;
        end else begin
            if (xi_valid) begin
                phase <= ~phase;
                cnt   <= cnt + 1'b1;
                i1    <= i1 + s;
                i2    <= i2 + i1;
                i3    <= i3 + i2;
            end
            tap_arm <= xi_valid && (cnt == '1);

            // Comb pipeline advances every clock, independent of input gaps.
            v0 <= tap_arm;
            v1 <= v0;
            v2 <= v1;
            yo_valid <= v2;
            if (tap_arm) begin
                x0 <= i3;
            end
            if (v0) begin
                c1 <= x0 - d1;
                d1 <= x0;
            end
            if (v1) begin
                c2 <= c1 - d2;
                d2 <= c1;
            end
            if (v2) begin
                d3 <= c2;
                yo <= y_sat;
            end
        end
    end

endmodule

// File: tb/tb_hpdsm_demod_decimator.sv
// Self-checking bench for hpdsm_demod_decimator (WIDTH=16, LOG2_DECIM=4):
// table of stream patterns, scoreboard of expected strobe times and values.
module tb_hpdsm_demod_decimator;

    localparam int DECIM = 16;

    typedef struct {
        logic first;   // bit of the first accepted sample
        logic alt;     // 1: alternate bits, 0: constant
        int   every;   // xi_valid asserted once every 'every' cycles
        int   blocks;  // number of DECIM-sample blocks
        int   exp_yo;  // steady-state output from the 3rd strobe on
    } vec_t;

    typedef struct {
        int   exp_cyc;
        logic chk_val;
        int   exp_yo;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic xi = 1'b0;
    logic xi_valid = 1'b0;
    logic signed [15:0] yo;
    logic yo_valid;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_yo = 0;
    logic rec_en = 1'b0;
    sb_t  sb[$];
    int   rec_q[$];

    hpdsm_demod_decimator #(.WIDTH(16), .LOG2_DECIM(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .xi       (xi),
        .xi_valid (xi_valid),
        .yo       (yo),
        .yo_valid (yo_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (yo_valid) begin
                check("strobe_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    check("strobe_cycle", cyc, e.exp_cyc);
                    if (e.chk_val) check("yo_value", int'(yo), e.exp_yo);
                    if (rec_en) rec_q.push_back(int'(yo));
                end
            end else begin
                check("yo_hold", int'(yo), last_yo);
            end
        end
        last_yo = int'(yo);
    end

    // Assert reset between clock edges, check the asynchronous clear, release at a falling edge.
    task automatic apply_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        xi_valid = 1'b0;
        #1;
        check("rst_yo", int'(yo), 0);
        check("rst_yo_valid", int'(yo_valid), 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb.size(), 0);
    endtask

    // use_ref=1: expected values come from the recorded sequence of the first table entry.
    task automatic run_stream(input vec_t v, input bit use_ref);
        int  acc;
        int  step;
        sb_t e;
        acc  = 0;
        step = 0;
        while (acc < v.blocks * DECIM) begin
            @(negedge clk);
            #1;
            if (step % v.every == 0) begin
                xi_valid = 1'b1;
                xi = v.alt ? (v.first ^ acc[0]) : v.first;
                acc++;
                if (acc % DECIM == 0) begin
                    e.exp_cyc = cyc + 5;
                    if (use_ref) begin
                        e.chk_val = 1'b1;
                        e.exp_yo  = (acc / DECIM - 1 < rec_q.size()) ? rec_q[acc/DECIM-1] : 99999;
                    end else begin
                        e.chk_val = (acc / DECIM >= 3);
                        e.exp_yo  = v.exp_yo;
                    end
                    sb.push_back(e);
                end
            end else begin
                xi_valid = 1'b0;
                xi = 1'($urandom);
            end
            step++;
        end
        @(negedge clk);
        #1 xi_valid = 1'b0;
    endtask

    task automatic random_accepts(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 xi_valid = 1'b1;
            xi = 1'($urandom);
        end
        @(negedge clk);
        #1 xi_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[6];
        sb_t  e;
        tbl[0] = '{first: 1'b1, alt: 1'b1, every: 1, blocks: 6, exp_yo: 32767};
        tbl[1] = '{first: 1'b0, alt: 1'b1, every: 1, blocks: 6, exp_yo: -32768};
        tbl[2] = '{first: 1'b1, alt: 1'b0, every: 1, blocks: 6, exp_yo: 0};
        tbl[3] = '{first: 1'b0, alt: 1'b0, every: 2, blocks: 5, exp_yo: 0};
        tbl[4] = '{first: 1'b1, alt: 1'b1, every: 3, blocks: 5, exp_yo: 32767};
        tbl[5] = '{first: 1'b0, alt: 1'b1, every: 1, blocks: 5, exp_yo: -32768};

        for (int t = 0; t < 6; t++) begin
            apply_reset();
            rec_en = (t == 0);
            run_stream(tbl[t], 1'b0);
            drain();
            rec_en = 1'b0;
        end
        check("ref_recorded", rec_q.size(), 6);

        // Reset mid-pipeline: the pending strobe must be dropped (scoreboard is cleared).
        random_accepts(DECIM - 1);
        @(negedge clk);
        #1 xi_valid = 1'b1;
        xi = 1'($urandom);
        e.exp_cyc = cyc + 5;
        e.chk_val = 1'b0;
        e.exp_yo  = 0;
        sb.push_back(e);
        @(negedge clk);
        #1 xi_valid = 1'b0;
        apply_reset();
        repeat (8) @(negedge clk);

        // Partial block of 7 accepts, reset, then the first pattern again: same yo sequence.
        random_accepts(7);
        apply_reset();
        run_stream(tbl[0], 1'b1);
        drain();

        repeat (24) @(negedge clk);
        check("sb_final_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
